// File: rtl/video_pkg.sv
// Shared types for the video processing chain: coordinate/pixel widths, pixel and box records,
// and the frame-sync state encoding.
package video_pkg;

    localparam int COORD_W = 11;
    localparam int PIX_W   = 8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic               valid;
    } bbox_t;

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } sync_state_t;

endpackage

// File: rtl/video_xy_counter.sv
// de/vs edge detection plus saturating x/y pixel counters; o_x/o_y give the coordinate of the
// pixel currently presented on the input.
module video_xy_counter
    import video_pkg::*;
#(
    parameter int H_RES = 64,
    parameter int V_RES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_de,
    input  logic               i_vs,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_vs_rise
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    logic               r_de_q;
    logic               r_vs_q;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_vs_rise;
    logic               w_de_fall;

    assign w_vs_rise = i_vs & ~r_vs_q;
    assign w_de_fall = ~i_de & r_de_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_de_q <= i_de;
            r_vs_q <= i_vs;

            if (w_de_fall)
                r_x <= '0;
            else if (i_de && r_x != X_MAX)
                r_x <= r_x + 1'b1;

            if (w_vs_rise)
                r_y <= '0;
            else if (w_de_fall && r_y != Y_MAX)
                r_y <= r_y + 1'b1;
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_vs_rise = w_vs_rise;

endmodule

// File: rtl/video_bbox_overlay.sv
// Colour-mask bounding-box tracker with 1-pixel outline overlay, fixed 2-cycle stream latency.
// Optional BBOX_MASK_VIEW_EN: non-border active pixels show the binary mask (white/black).
module video_bbox_overlay
    import video_pkg::*;
#(
    parameter int                 H_RES     = 64,
    parameter int                 V_RES     = 64,
    parameter logic [PIX_W-1:0]   R_TH      = 8'd128,
    parameter logic [PIX_W-1:0]   G_TH      = 8'd64,
    parameter logic [PIX_W-1:0]   B_TH      = 8'd64,
    parameter logic [3*PIX_W-1:0] BOX_COLOR = 24'h00FF00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [PIX_W-1:0]   r_in,
    input  logic [PIX_W-1:0]   g_in,
    input  logic [PIX_W-1:0]   b_in,
    output logic               de_out,
    output logic               hs_out,
    output logic               vs_out,
    output logic [PIX_W-1:0]   r_out,
    output logic [PIX_W-1:0]   g_out,
    output logic [PIX_W-1:0]   b_out,
    output logic [COORD_W-1:0] bbox_x_min,
    output logic [COORD_W-1:0] bbox_x_max,
    output logic [COORD_W-1:0] bbox_y_min,
    output logic [COORD_W-1:0] bbox_y_max,
    output logic               bbox_valid,
    output logic               frame_done
);

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_vs_rise;
    logic               w_mask;

    video_xy_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_xy (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_de      (de_in),
        .i_vs      (vs_in),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_vs_rise (w_vs_rise)
    );

    assign w_mask = de_in & (r_in >= R_TH) & (g_in < G_TH) & (b_in < B_TH);

    // Frame-boundary FSM
    sync_state_t r_state;
    sync_state_t w_state_next;
    logic        w_publish;
    logic        w_acc_clear;
    logic        w_acc_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_SYNC;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_WAIT_SYNC && w_vs_rise)
            w_state_next = ST_RUN;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_publish   = 1'b0;
        w_acc_clear = w_vs_rise;
        w_acc_en    = 1'b0;
        if (r_state == ST_RUN) begin
            w_publish = w_vs_rise;
            w_acc_en  = w_mask & ~w_vs_rise;
        end
    end

    // Accumulator and published box
    bbox_t r_acc;
    bbox_t r_box;
    logic  r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_box        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_publish;
            if (w_publish)
                r_box <= r_acc.valid ? r_acc : '0;

            if (w_acc_clear) begin
                r_acc <= '0;
            end else if (w_acc_en) begin
                if (!r_acc.valid) begin
                    r_acc <= '{xmin: w_x, xmax: w_x, ymin: w_y, ymax: w_y, valid: 1'b1};
                end else begin
                    if (w_x < r_acc.xmin) r_acc.xmin <= w_x;
                    if (w_x > r_acc.xmax) r_acc.xmax <= w_x;
                    if (w_y < r_acc.ymin) r_acc.ymin <= w_y;
                    if (w_y > r_acc.ymax) r_acc.ymax <= w_y;
                end
            end
        end
    end

    // Stage 1: registered stream, coordinates and mask
    logic               r_s1_de, r_s1_hs, r_s1_vs;
    rgb_t               r_s1_rgb;
    logic [COORD_W-1:0] r_s1_x, r_s1_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_de  <= 1'b0;
            r_s1_hs  <= 1'b0;
            r_s1_vs  <= 1'b0;
            r_s1_rgb <= '0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
        end else begin
            r_s1_de  <= de_in;
            r_s1_hs  <= hs_in;
            r_s1_vs  <= vs_in;
            r_s1_rgb <= '{r: r_in, g: g_in, b: b_in};
            r_s1_x   <= w_x;
            r_s1_y   <= w_y;
        end
    end

`ifdef BBOX_MASK_VIEW_EN
    logic r_s1_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s1_mask <= 1'b0;
        else        r_s1_mask <= w_mask;
    end
`endif

    // Overlay mux feeding stage 2
    logic w_x_in, w_y_in, w_x_edge, w_y_edge, w_on_border;
    rgb_t w_pix;

    assign w_x_in      = (r_s1_x >= r_box.xmin) && (r_s1_x <= r_box.xmax);
    assign w_y_in      = (r_s1_y >= r_box.ymin) && (r_s1_y <= r_box.ymax);
    assign w_x_edge    = (r_s1_x == r_box.xmin) || (r_s1_x == r_box.xmax);
    assign w_y_edge    = (r_s1_y == r_box.ymin) || (r_s1_y == r_box.ymax);
    assign w_on_border = r_s1_de && r_box.valid && ((w_x_edge && w_y_in) || (w_y_edge && w_x_in));

    always_comb begin
        w_pix = r_s1_rgb;
`ifdef BBOX_MASK_VIEW_EN
        if (r_s1_de)
            w_pix = r_s1_mask ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
`endif
        if (w_on_border)
            w_pix = rgb_t'(BOX_COLOR);
    end

    // Stage 2: registered output stream
    logic r_s2_de, r_s2_hs, r_s2_vs;
    rgb_t r_s2_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_de  <= 1'b0;
            r_s2_hs  <= 1'b0;
            r_s2_vs  <= 1'b0;
            r_s2_rgb <= '0;
        end else begin
            r_s2_de  <= r_s1_de;
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_rgb <= w_pix;
        end
    end

    assign de_out     = r_s2_de;
    assign hs_out     = r_s2_hs;
    assign vs_out     = r_s2_vs;
    assign r_out      = r_s2_rgb.r;
    assign g_out      = r_s2_rgb.g;
    assign b_out      = r_s2_rgb.b;
    assign bbox_x_min = r_box.xmin;
    assign bbox_x_max = r_box.xmax;
    assign bbox_y_min = r_box.ymin;
    assign bbox_y_max = r_box.ymax;
    assign bbox_valid = r_box.valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_video_bbox_overlay.sv
// Directed bench for video_bbox_overlay: 64x64 frames with hand-computed boxes and outline pixels,
// plus a 2-cycle control latency check on a random stream.
module tb_video_bbox_overlay;

    localparam int M_BLACK   = 0;
    localparam int M_BLOCK   = 1;
    localparam int M_PIX00   = 2;
    localparam int M_PIX6363 = 3;
    localparam int M_THRESH  = 4;

    localparam logic [31:0] GREEN = 'h00FF00;
`ifdef BBOX_MASK_VIEW_EN
    localparam logic [31:0] EXP_RED     = 'hFFFFFF;
    localparam logic [31:0] EXP_TH_IN   = 'hFFFFFF;
    localparam logic [31:0] EXP_TH_OUT  = 'h000000;
`else
    localparam logic [31:0] EXP_RED     = 'hFF0000;
    localparam logic [31:0] EXP_TH_IN   = 'h803F3F;
    localparam logic [31:0] EXP_TH_OUT  = 'h7F0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        de_out, hs_out, vs_out;
    logic [7:0]  r_out, g_out, b_out;
    logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic        bbox_valid, frame_done;

    always #5 clk = ~clk;

    video_bbox_overlay dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .bbox_x_min (bbox_x_min),
        .bbox_x_max (bbox_x_max),
        .bbox_y_min (bbox_y_min),
        .bbox_y_max (bbox_y_max),
        .bbox_valid (bbox_valid),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output capture: rebuild the output frame from de_out/vs_out and count frame_done pulses.
    logic [23:0] img [64][64];
    int          ox = 0, oy = 0, fd_total = 0;
    logic        pde = 1'b0, pvs = 1'b0;

    always @(negedge clk) begin
        if (vs_out && !pvs) begin
            ox = 0;
            oy = 0;
        end
        if (de_out) begin
            if (ox < 64 && oy < 64) img[oy][ox] = {r_out, g_out, b_out};
            ox++;
        end else if (pde) begin
            ox = 0;
            oy++;
        end
        if (frame_done) fd_total++;
        pvs = vs_out;
        pde = de_out;
    end

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        case (mode)
            M_BLOCK:   return (x >= 10 && x <= 19 && y >= 5 && y <= 8) ? 24'hFF0000 : 24'h000000;
            M_PIX00:   return (x == 0 && y == 0) ? 24'hFF0000 : 24'h000000;
            M_PIX6363: return (x == 63 && y == 63) ? 24'hFF0000 : 24'h000000;
            M_THRESH: begin
                if (y != 30) return 24'h000000;
                case (x)
                    20:      return 24'h803F3F;
                    21:      return 24'h7F0000;
                    22:      return 24'hFF4000;
                    23:      return 24'hFF0040;
                    default: return 24'h000000;
                endcase
            end
            default:   return 24'h000000;
        endcase
    endfunction

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
        @(negedge clk);
        de_in = de;
        hs_in = hs;
        vs_in = vs;
        {r_in, g_in, b_in} = rgb;
    endtask

    // One frame: vs pulse, 64 lines of 64 active pixels with hsync blanking; stops mid-line 30 at
    // x=32 when abort_line matches, leaving de high.
    task automatic send_frame(input int mode, input int abort_line, output int fd_cnt);
        int snap;
        snap = fd_total;
        repeat (4) drive(1'b0, 1'b0, 1'b1, 24'h0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);
        for (int l = 0; l < 64; l++) begin
            for (int x = 0; x < 64; x++) begin
                if (l == abort_line && x == 32) begin
                    fd_cnt = fd_total - snap;
                    return;
                end
                drive(1'b1, 1'b0, 1'b0, pix(mode, x, l));
            end
            repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
            repeat (3) drive(1'b0, 1'b1, 1'b0, 24'h0);
            repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 24'h0);
        fd_cnt = fd_total - snap;
    endtask

    task automatic check_box(input string tag, input int xmin, input int xmax,
                             input int ymin, input int ymax, input int valid);
        check({tag, "_xmin"},  32'(bbox_x_min), xmin);
        check({tag, "_xmax"},  32'(bbox_x_max), xmax);
        check({tag, "_ymin"},  32'(bbox_y_min), ymin);
        check({tag, "_ymax"},  32'(bbox_y_max), ymax);
        check({tag, "_valid"}, 32'(bbox_valid), valid);
    endtask

    task automatic check_px(input string tag, input int x, input int y, input logic [31:0] exp);
        check(tag, 32'(img[y][x]), exp);
    endtask

    initial begin
        int          fd;
        logic [2:0]  h1, h2, cur;
        logic [23:0] rgb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_de_out",     32'(de_out), 0);
        check("rst_rgb_out",    32'({r_out, g_out, b_out}), 0);
        check("rst_bbox_valid", 32'(bbox_valid), 0);
        check("rst_bbox_xmax",  32'(bbox_x_max), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;

        // Control latency on a random stream: outputs equal inputs from exactly 2 cycles earlier
        h1 = '0;
        h2 = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("latency_ctrl", 32'({de_out, hs_out, vs_out}), 32'(h2));
            cur = 3'($urandom_range(0, 7));
            rgb = 24'($urandom);
            {de_in, hs_in, vs_in} = cur;
            {r_in, g_in, b_in}    = rgb;
            h2 = h1;
            h1 = cur;
        end

        // Clean restart
        @(negedge clk);
        {de_in, hs_in, vs_in} = '0;
        {r_in, g_in, b_in}    = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A: sync frame with red block; no publish, block passes through
        send_frame(M_BLOCK, -1, fd);
        check("A_frame_done", fd, 0);
        check("A_valid", 32'(bbox_valid), 0);
        check_px("A_px15_6", 15, 6, EXP_RED);
        check_px("A_px0_0", 0, 0, 0);

        // B: publishes block box, outline drawn on black frame
        send_frame(M_BLACK, -1, fd);
        check("B_frame_done", fd, 1);
        check_box("B", 10, 19, 5, 8, 1);
        check_px("B_px10_5", 10, 5, GREEN);
        check_px("B_px19_7", 19, 7, GREEN);
        check_px("B_px15_8", 15, 8, GREEN);
        check_px("B_px15_6", 15, 6, 0);
        check_px("B_px9_5", 9, 5, 0);

        // C: empty frame published; no outline
        send_frame(M_PIX00, -1, fd);
        check("C_frame_done", fd, 1);
        check_box("C", 0, 0, 0, 0, 0);
        check_px("C_px10_5", 10, 5, 0);
        check_px("C_px0_0", 0, 0, EXP_RED);

        // D: single pixel box at origin
        send_frame(M_PIX6363, -1, fd);
        check("D_frame_done", fd, 1);
        check_box("D", 0, 0, 0, 0, 1);
        check_px("D_px0_0", 0, 0, GREEN);
        check_px("D_px1_0", 1, 0, 0);

        // E: single pixel box at far corner; threshold pixels on line 30
        send_frame(M_THRESH, -1, fd);
        check("E_frame_done", fd, 1);
        check_box("E", 63, 63, 63, 63, 1);
        check_px("E_px63_63", 63, 63, GREEN);
        check_px("E_px62_63", 62, 63, 0);
        check_px("E_px20_30", 20, 30, EXP_TH_IN);
        check_px("E_px21_30", 21, 30, EXP_TH_OUT);

        // F: only the in-threshold pixel counted
        send_frame(M_BLOCK, -1, fd);
        check("F_frame_done", fd, 1);
        check_box("F", 20, 20, 30, 30, 1);
        check_px("F_px20_30", 20, 30, GREEN);
        check_px("F_px21_30", 21, 30, 0);
        check_px("F_px15_6", 15, 6, EXP_RED);

        // Reset mid-frame at line 30
        send_frame(M_BLACK, 30, fd);
        check("pre_rst_de_out", 32'(de_out), 1);
        check_box("pre_rst", 10, 19, 5, 8, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_de_out", 32'(de_out), 0);
        check("mid_rst_rgb", 32'({r_out, g_out, b_out}), 0);
        check("mid_rst_frame_done", 32'(frame_done), 0);
        check_box("mid_rst", 0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        rst_n = 1'b1;

        // G: first vs after reset only syncs
        send_frame(M_PIX6363, -1, fd);
        check("G_frame_done", fd, 0);
        check("G_valid", 32'(bbox_valid), 0);

        // H: publishes G's box
        send_frame(M_BLACK, -1, fd);
        check("H_frame_done", fd, 1);
        check_box("H", 63, 63, 63, 63, 1);
        check_px("H_px63_63", 63, 63, GREEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_bbox_overlay.md
Name: video_bbox_overlay

Overview:
- Downstream consumer of the HDMI-style pixel stream (de/hs/vs + 8-bit R/G/B) produced by the input timing/video source.
- Thresholds each pixel into a colour mask and tracks the mask's bounding box over a frame.
- At each frame boundary, publishes the box and draws its 1-pixel outline on the following frame.
- Output stream keeps identical timing, delayed by a fixed 2 cycles; feeds the output/encoder stage.

Parameters:
- H_RES, 64, active pixels per line (saturation bound for x).
- V_RES, 64, active lines per frame (saturation bound for y).
- R_TH, 8'd128, mask requires R >= R_TH.
- G_TH, 8'd64, mask requires G < G_TH.
- B_TH, 8'd64, mask requires B < B_TH.
- BOX_COLOR, 24'h00FF00, {R,G,B} used for outline pixels.

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  data enable, active high
- hs_in  in  1  hsync, active high
- vs_in  in  1  vsync, active high
- r_in, g_in, b_in  in  8 each  pixel colour
- de_out, hs_out, vs_out  out  1 each  control signals delayed by 2 cycles
- r_out, g_out, b_out  out  8 each  processed pixel, aligned with de_out
- bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  out  11 each  published box for the last complete frame
- bbox_valid  out  1  published box contains at least one mask pixel
- frame_done  out  1  one-cycle pulse when a new box is published

Behaviour:
- Reset: all outputs and internal registers are 0; the accumulator is invalid; the synced flag is cleared.
- Timing:
  - Stage 1 registers the inputs, x/y and the mask.
  - Stage 2 registers the overlay mux.
  - Latency is exactly 2 cycles for de/hs/vs/rgb.
- Edge detect: vs_rise = vs_in & ~vs_q; de_fall = ~de_in & de_q (both registered previous values).
- Coordinates:
  - x counts de_in-high cycles from 0; it resets to 0 on de_fall.
  - y increments on de_fall and resets to 0 on vs_rise.
  - Both saturate at H_RES-1 / V_RES-1.
- Mask = de_in & (r_in >= R_TH) & (g_in < G_TH) & (b_in < B_TH). Comparisons are unsigned.
- Accumulator:
  - Holds acc_valid, acc_xmin, acc_xmax, acc_ymin, acc_ymax.
  - First mask pixel of a frame loads all four fields from x/y and sets acc_valid.
  - Each later mask pixel updates min/max.
- Frame boundary state machine, states WAIT_SYNC and RUN:
  - WAIT_SYNC: entered after reset. The accumulator is ignored; the first vs_rise moves to RUN with a cleared accumulator. No publish happens on this transition.
  - RUN, on vs_rise: copy the accumulator to the bbox_* outputs, set bbox_valid = acc_valid, pulse frame_done the next cycle, then clear the accumulator.
  - If acc_valid = 0 at publish, bbox_* are forced to 0 and bbox_valid = 0.
- Simultaneous vs_rise and de_in = 1 (non-compliant input): vs_rise wins; that pixel is not accumulated.
- Overlay:
  - In stage 2, when bbox_valid and de, a pixel is on the border if x∈{xmin,xmax} with y∈[ymin,ymax], or y∈{ymin,ymax} with x∈[xmin,xmax].
  - Border pixels output BOX_COLOR; all others pass through unchanged.
  - When de is low, rgb passes through (don't care downstream).
- Published values are stable for the whole next frame and change only at vs_rise.
- Reset mid-frame: everything clears immediately and the block returns to WAIT_SYNC. The partial frame is neither accumulated nor overlaid.

Optional Feature:
- Macro: BBOX_MASK_VIEW_EN.
- Defined: non-border active pixels output 24'hFFFFFF when the mask is set, 24'h000000 otherwise (binary mask view). The border overlay still takes priority.
- Undefined: non-border pixels pass through the original RGB.

Decomposition:
- Shared package video_pkg:
  - COORD_W = 11 and PIX_W = 8.
  - typedef rgb_t as a packed {r,g,b}.
  - typedef bbox_t as {xmin,xmax,ymin,ymax,valid}.
  - Enum for WAIT_SYNC/RUN.
- One natural sub-module, video_xy_counter: de/vs edge detection plus saturating x/y counters. It is reusable by later stages.

Test Plan:
- 64x64 black frames; red (FF,00,00) block at x=10..19, y=5..8 → after vs_rise: bbox=(10,19,5,8), bbox_valid=1, frame_done one pulse. Next frame: pixels (10,5), (19,7), (15,8) are 00FF00; (15,6) is black.
- Frame with no mask pixels → bbox_* = 0, bbox_valid = 0, no outline drawn the next frame; frame_done still pulses.
- Single mask pixel at (0,0) and a second frame with a single pixel at (63,63) → boxes (0,0,0,0) and (63,63,63,63); 1-pixel outline at that location.
- Threshold edges: R=128,G=63,B=63 is in the mask; R=127 or G=64 is out → bbox reflects only the in-mask pixel.
- Assert rst_n low mid-frame at line 30 → outputs 0 within the same cycle. The first vs_rise after release does not publish; the frame after that publishes correctly.
- Latency check: random stream → de/hs/vs_out equal inputs delayed exactly 2 cycles. With BBOX_MASK_VIEW_EN, the mask pixel outputs FFFFFF and a non-mask pixel outputs 000000.
